// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the counter round-robin scheduler.
// Holds the arbiter state encoding and the default channel/counter sizing.
package cnt_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 4;

    // Index width that stays legal for a single-channel build.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_rr_sched_arb.sv
// Combinational round-robin search: first eligible channel after the last winner.
module rr_arb
    import cnt_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = idxWidth(DEF_NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [IDX_W-1:0]  last_gnt_idx_i,
    output logic [IDX_W-1:0]  win_idx_o,
    output logic              valid_o
);

    // Offsets 1..NUM_CH visit every channel once, ending on the last winner itself.
    always_comb begin
        int idx;
        valid_o   = 1'b0;
        win_idx_o = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_gnt_idx_i) + k) % NUM_CH;
            if (!valid_o && eligible_i[idx]) begin
                valid_o   = 1'b1;
                win_idx_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cnt_rr_sched.sv
// Per-channel counters sharing one incrementer, granted round-robin one channel per cycle.
// Grants and wrap flags are registered and describe the increment committed at the last edge.
module cnt_rr_sched
    import cnt_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       gnt,
    output logic [NUM_CH-1:0]       wrap,
    output logic [NUM_CH*CNT_W-1:0] cnt_all,
    output logic                    busy
);

    localparam int IDX_W = idxWidth(NUM_CH);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] wrap_q, wrap_d;
    logic [IDX_W-1:0]  lastIdx_q, lastIdx_d;

    logic [NUM_CH-1:0] eligible;
    logic [IDX_W-1:0]  winIdx;
    logic              winValid;
    logic              grantNow;
    logic [CNT_W-1:0]  curCnt;
    logic [CNT_W-1:0]  incCnt;
    logic              carry;

    // A channel granted last cycle sits out one cycle, so a held request gets every other slot.
    always_comb begin
        eligible = req & ~clr;
        if (state_q == GRANT) begin
            eligible = eligible & ~gnt_q;
        end
    end

    rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .eligible_i     (eligible),
        .last_gnt_idx_i (lastIdx_q),
        .win_idx_o      (winIdx),
        .valid_o        (winValid)
    );

    assign grantNow = en & winValid;

    // busy is masked by reset so every output reads zero while rst_n is low.
    assign busy = en & rst_n & (|eligible);

    always_comb begin
        curCnt          = cnt_q[winIdx];
        {carry, incCnt} = {1'b0, curCnt} + {{CNT_W{1'b0}}, grantNow};
    end

    always_comb begin
        state_d   = grantNow ? GRANT : IDLE;
        gnt_d     = '0;
        wrap_d    = '0;
        lastIdx_d = lastIdx_q;
        cnt_d     = cnt_q;
        if (state_d == GRANT) begin
            gnt_d[winIdx]  = 1'b1;
            wrap_d[winIdx] = carry;
            lastIdx_d      = winIdx;
            cnt_d[winIdx]  = incCnt;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Reset leaves the last winner at the top channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            wrap_q    <= '0;
            lastIdx_q <= IDX_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wrap_q    <= wrap_d;
            lastIdx_q <= lastIdx_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gnt  = gnt_q;
    assign wrap = wrap_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign cnt_all[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_wrap_in_gnt : assert property (@(posedge clk) disable iff (!rst_n) (wrap_q & ~gnt_q) == '0);

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Self-checking bench for cnt_rr_sched: integer-level scheduler model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cnt_rr_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       gnt;
    logic [NUM_CH-1:0]       wrap;
    logic [NUM_CH*CNT_W-1:0] cnt_all;
    logic                    busy;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    int mCnt [NUM_CH];
    int mLast = NUM_CH - 1;
    int mGnt  = -1;
    int mWrap = -1;

    cnt_rr_sched #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .clr     (clr),
        .gnt     (gnt),
        .wrap    (wrap),
        .cnt_all (cnt_all),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Scheduler model: integer counters, last winner and last granted channel.
    always @(posedge clk or negedge rst_n) begin
        int win;
        int c;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) mCnt[i] = 0;
            mLast = NUM_CH - 1;
            mGnt  = -1;
            mWrap = -1;
        end else begin
            win = -1;
            if (en) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (mLast + k) % NUM_CH;
                    if (win < 0 && req[c] && !clr[c] && mGnt != c) win = c;
                end
            end
            mWrap = -1;
            if (win >= 0) begin
                if (mCnt[win] == MAXV) begin
                    mCnt[win] = 0;
                    mWrap = win;
                end else begin
                    mCnt[win] = mCnt[win] + 1;
                end
                mLast = win;
            end
            mGnt = win;
            for (int i = 0; i < NUM_CH; i++) if (clr[i]) mCnt[i] = 0;
        end
    end

    function automatic logic [NUM_CH-1:0] oneHot(input int idx);
        logic [NUM_CH-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] expCntAll();
        logic [NUM_CH*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(mCnt[i]);
        return v;
    endfunction

    function automatic logic expBusy();
        logic b;
        b = 1'b0;
        if (rst_n && en) begin
            for (int i = 0; i < NUM_CH; i++) if (req[i] && !clr[i] && mGnt != i) b = 1'b1;
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] c);
        en  = e;
        req = r;
        clr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        en    = 1'b0;
        req   = '0;
        clr   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_gnt", 64'(gnt), 64'(oneHot(mGnt)));
            checkOutput("model_wrap", 64'(wrap), 64'(oneHot(mWrap)));
            checkOutput("model_cnt_all", 64'(cnt_all), 64'(expCntAll()));
            checkOutput("model_busy", 64'(busy), 64'(expBusy()));
        end
    end

    initial begin
        logic [NUM_CH-1:0] pat1 [4];
        logic [NUM_CH-1:0] pat2 [8];
        pat1 = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        pat2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        clr   = '0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_gnt", 64'(gnt), 64'h0);
        checkOutput("reset_wrap", 64'(wrap), 64'h0);
        checkOutput("reset_cnt_all", 64'(cnt_all), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        rst_n    = 1'b1;
        checking = 1'b1;

        // Held single request: grant every other cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0000);
            checkOutput("held_req_gnt", 64'(gnt), 64'(pat1[i]));
        end
        checkOutput("held_req_cnt", 64'(cnt_all), 64'h0002);
        applyStimulus(1'b0, 4'b0000, 4'b0000);

        // All channels requesting: rotating order from channel 0.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000);
            checkOutput("rr_order_gnt", 64'(gnt), 64'(pat2[i]));
        end
        checkOutput("rr_cnt_all", 64'(cnt_all), 64'h2222);
        applyStimulus(1'b0, 4'b0000, 4'b0000);

        // Wrap-around on channel 2.
        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 4'b0100, 4'b0000);
            applyStimulus(1'b1, 4'b0000, 4'b0000);
        end
        checkOutput("preload_cnt", 64'(cnt_all), 64'h0F00);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        checkOutput("wrap_gnt", 64'(gnt), 64'h4);
        checkOutput("wrap_flag", 64'(wrap), 64'h4);
        checkOutput("wrap_cnt", 64'(cnt_all), 64'h0000);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("wrap_drop", 64'(wrap), 64'h0);

        // Clear beats request; disabled scheduler never grants.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0000);
            applyStimulus(1'b1, 4'b0000, 4'b0000);
        end
        checkOutput("ch1_preload", 64'(cnt_all), 64'h0050);
        applyStimulus(1'b1, 4'b0010, 4'b0010);
        checkOutput("clr_gnt", 64'(gnt), 64'h0);
        checkOutput("clr_cnt", 64'(cnt_all), 64'h0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0010, 4'b0000);
            checkOutput("en_low_cnt", 64'(cnt_all), 64'h0000);
            checkOutput("en_low_gnt", 64'(gnt), 64'h0);
            checkOutput("en_low_busy", 64'(busy), 64'h0);
        end

        // Asynchronous reset mid-cycle under full load.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_gnt", 64'(gnt), 64'h0);
        checkOutput("async_rst_wrap", 64'(wrap), 64'h0);
        checkOutput("async_rst_cnt", 64'(cnt_all), 64'h0);
        checkOutput("async_rst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("post_rst_gnt", 64'(gnt), 64'h1);
        checkOutput("post_rst_cnt", 64'(cnt_all), 64'h0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
